instr_fetch: RTL and testbench

Instruction-fetch stage of the 5-stage MIPS pipeline, and the producer of the 32-bit `instr` word that the decode-stage control unit consumes. It holds the PC and drives a synchronous instruction memory with a fixed 1-cycle read latency. It captures returning words in a 1-entry skid buffer while the pipeline is stalled, and presents `instr`, `pc_out` and `pc_plus4` through the IF/ID register. It honours stall, flush and jump/branch redirect requests from the decode and hazard logic.

---
 rtl/mips_if_pkg.sv | 27 ++
 rtl/if_skid_buf.sv | 35 +++
 rtl/instr_fetch.sv | 124 ++++++++++++
 tb/tb_instr_fetch.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_if_pkg.sv
// mips_if_pkg: shared FSM type, reset defaults and fetch-entry record
// for the instruction-fetch stage.
package mips_if_pkg;

  // BOOT: first cycle out of reset; RUN: skid empty; HOLD: skid full.
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } ifState_t;

  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;  // sll $0,$0,0
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  // One fetched word together with the address it came from.
  typedef struct packed {
    logic [31:0] word;
    logic [31:0] addr;
    logic        valid;
  } fetchEntry_t;

  // Instruction addresses are word addresses; the low two bits are dropped.
  function automatic logic [31:0] alignPc(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/if_skid_buf.sv
// if_skid_buf: one-entry capture register for a fetched word that
// returns from memory while decode is stalled.
module if_skid_buf
  import mips_if_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] loadWord,
  input  logic [31:0] loadAddr,
  output logic        valid,
  output logic [31:0] word,
  output logic [31:0] addr
);

  fetchEntry_t entry;

  // Capture on load, release on clear; the two never coincide since
  // load happens only while stalled and clear only when not stalled.
  always_ff @(posedge clk) begin
    if (!rst) begin
      entry <= '0;
    end else if (load) begin
      entry <= '{word: loadWord, addr: loadAddr, valid: 1'b1};
    end else if (clear) begin
      entry.valid <= 1'b0;
    end
  end

  assign valid = entry.valid;
  assign word  = entry.word;
  assign addr  = entry.addr;

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: MIPS IF stage. Holds the PC, drives a 1-cycle-latency
// instruction memory, parks a returning word in a skid buffer during
// stalls and presents it through the IF/ID register.
// Build option: define IF_DELAY_SLOT_EN to keep the branch delay-slot
// word on redirect; otherwise that slot becomes a bubble.
module instr_fetch
  import mips_if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4
);

  ifState_t    state;
  logic [31:0] pc;
  logic        f2Valid;
  logic [31:0] f2Addr;
  fetchEntry_t ifId;
  fetchEntry_t ifIdNext;

  logic        skidValid;
  logic [31:0] skidWord;
  logic [31:0] skidAddr;

  logic        advance;
  logic        fetchGo;
  logic        skidLoad;
  logic        skidClear;
  logic        pendValid;
  logic        keepSlot;
  logic [31:0] pendWord;
  logic [31:0] pendAddr;

  // The pipeline moves whenever decode is not stalled, except in BOOT.
  assign advance   = (state != BOOT) && !stall;
  // A redirect suppresses the fetch of the now-dead sequential address.
  assign fetchGo   = rst && advance && !redirect;
  assign skidLoad  = (state == RUN) && stall && f2Valid;
  assign skidClear = (state == HOLD) && !stall;

  // Oldest pending word: skid when full (F2 is then empty), else F2.
  assign pendValid = skidValid || f2Valid;
  assign pendWord  = skidValid ? skidWord : imem_rdata;
  assign pendAddr  = skidValid ? skidAddr : f2Addr;

`ifdef IF_DELAY_SLOT_EN
  assign keepSlot = pendValid;
`else
  assign keepSlot = pendValid && !redirect;
`endif

  if_skid_buf u_skid (
    .clk      (clk),
    .rst      (rst),
    .load     (skidLoad),
    .clear    (skidClear),
    .loadWord (imem_rdata),
    .loadAddr (f2Addr),
    .valid    (skidValid),
    .word     (skidWord),
    .addr     (skidAddr)
  );

  // Next IF/ID contents: flush beats stall, stall holds, else load or bubble.
  always_comb begin
    ifIdNext = ifId;
    if (flush) begin
      ifIdNext = '{word: NOP_WORD, addr: ifId.addr, valid: 1'b0};
    end else if (advance) begin
      if (keepSlot) begin
        ifIdNext = '{word: pendWord, addr: pendAddr, valid: 1'b1};
      end else begin
        ifIdNext = '{word: NOP_WORD, addr: ifId.addr, valid: 1'b0};
      end
    end
  end

  // FSM, PC, F2 tracking and the IF/ID register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= BOOT;
      pc      <= alignPc(RESET_PC);
      f2Valid <= 1'b0;
      f2Addr  <= alignPc(RESET_PC);
      ifId    <= '{word: NOP_WORD, addr: RESET_PC, valid: 1'b0};
    end else begin
      ifId    <= ifIdNext;
      f2Valid <= fetchGo;
      if (fetchGo) begin
        f2Addr <= pc;
        pc     <= pc + 32'd4;
      end else if (advance && redirect) begin
        pc <= alignPc(redirect_target);
      end
      case (state)
        BOOT:    state <= RUN;
        RUN:     if (skidLoad) state <= HOLD;
        HOLD:    if (skidClear) state <= RUN;
        default: state <= BOOT;
      endcase
    end
  end

  assign imem_req    = fetchGo;
  assign imem_addr   = pc;
  assign instr       = ifId.word;
  assign instr_valid = ifId.valid;
  assign pc_out      = ifId.addr;
  assign pc_plus4    = ifId.addr + 32'd4;

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed and randomized checks of instr_fetch against a
// queue-based model of the fetch stream. Memory returns addr>>2.
module tb_instr_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] NOP      = 32'h0000_0000;
`ifdef IF_DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        flush;
  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;

  int checks = 0;
  int errors = 0;

  // Reference state: fetched-but-undelivered addresses in age order.
  bit          mBoot = 1'b1;
  logic [31:0] mPc = RESET_PC;
  logic [31:0] mPend[$];
  logic [31:0] mInstr = NOP;
  logic [31:0] mPcOut = RESET_PC;
  bit          mValid = 1'b0;

  instr_fetch dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .stall           (stall),
    .flush           (flush),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .instr           (instr),
    .instr_valid     (instr_valid),
    .pc_out          (pc_out),
    .pc_plus4        (pc_plus4)
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory; garbage when no request was made.
  always_ff @(posedge clk) begin
    imem_rdata <= imem_req ? (imem_addr >> 2) : 32'hDEAD_BEEF;
  end

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Advance the model by one clock edge with the given inputs.
  task automatic modelStep(input bit rn, input bit st, input bit fl, input bit rd,
                           input logic [31:0] tg);
    logic [31:0] oldest;
    bit          have;
    bit          deliver;
    if (!rn) begin
      mBoot  = 1'b1;
      mPc    = RESET_PC;
      mPend.delete();
      mInstr = NOP;
      mValid = 1'b0;
      mPcOut = RESET_PC;
      return;
    end
    if (mBoot) begin
      mBoot = 1'b0;
    end else if (!st) begin
      have    = (mPend.size() != 0);
      oldest  = '0;
      deliver = 1'b0;
      if (have) oldest = mPend.pop_front();
      if (rd) begin
        mPend.delete();
        deliver = have && DS;
        mPc     = tg & 32'hFFFF_FFFC;
      end else begin
        deliver = have;
        mPend.push_back(mPc);
        mPc = mPc + 32'd4;
      end
      if (deliver) begin
        mInstr = oldest >> 2;
        mValid = 1'b1;
        mPcOut = oldest;
      end else begin
        mInstr = NOP;
        mValid = 1'b0;
      end
    end
    if (fl) begin
      mInstr = NOP;
      mValid = 1'b0;
    end
  endtask

  // One clock: drive inputs, check the fetch request, clock, check IF/ID.
  task automatic doCycle(input bit rn, input bit st, input bit fl, input bit rd,
                         input logic [31:0] tg);
    bit expReq;
    rst             = rn;
    stall           = st;
    flush           = fl;
    redirect        = rd;
    redirect_target = tg;
    #1;
    expReq = rn && !mBoot && !st && !rd;
    checkEq("imem_req", 32'(imem_req), 32'(expReq));
    if (expReq) checkEq("imem_addr", imem_addr, mPc);
    modelStep(rn, st, fl, rd, tg);
    @(posedge clk);
    @(negedge clk);
    checkEq("instr_valid", 32'(instr_valid), 32'(mValid));
    checkEq("instr", instr, mInstr);
    if (mValid) begin
      checkEq("pc_out", pc_out, mPcOut);
      checkEq("pc_plus4", pc_plus4, mPcOut + 32'd4);
      $display("IFID pc=%08h instr=%08h", pc_out, instr);
    end
  endtask

  task automatic doReset();
    doCycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    doCycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    bit          rn;
    bit          st;
    bit          fl;
    bit          rd;
    logic [31:0] tg;

    rst = 1'b0; stall = 1'b0; flush = 1'b0; redirect = 1'b0; redirect_target = '0;
    @(negedge clk);

    // Reset values.
    doReset();
    checkEq("rst_req", 32'(imem_req), 32'h0);
    checkEq("rst_addr", imem_addr, RESET_PC);
    checkEq("rst_pc_out", pc_out, RESET_PC);
    checkEq("rst_pc_plus4", pc_plus4, RESET_PC + 32'd4);

    // Release: BOOT, first request, then one word per cycle.
    doCycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    doCycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    checkEq("first_invalid", 32'(instr_valid), 32'h0);
    for (int i = 0; i < 3; i++) begin
      doCycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      checkEq("seq_pc", pc_out, RESET_PC + 32'(4 * i));
    end

    // Three-cycle stall mid-stream.
    for (int i = 0; i < 3; i++) doCycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    checkEq("stall_hold", pc_out, 32'h0000_3008);
    doCycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    checkEq("stall_next", pc_out, 32'h0000_300C);
    doCycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);

    // Flush together with stall.
    doCycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    checkEq("fs_instr", instr, 32'h0);
    checkEq("fs_valid", 32'(instr_valid), 32'h0);
    checkEq("fs_pc", imem_addr, mPc);
    doCycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    doCycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);

    // Redirect to 0x3100 while 0x3008 is in flight.
    doReset();
    for (int i = 0; i < 4; i++) doCycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    doCycle(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_3100);
    checkEq("ds_valid", 32'(instr_valid), 32'(DS));
    checkEq("ds_instr", instr, DS ? 32'h0000_0C02 : NOP);
    checkEq("redir_addr", imem_addr, 32'h0000_3100);
    doCycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    checkEq("redir_bubble", 32'(instr_valid), 32'h0);
    doCycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    checkEq("redir_target_pc", pc_out, 32'h0000_3100);
    checkEq("redir_target_instr", instr, 32'h0000_0C40);

    // Unaligned target.
    doCycle(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_3103);
    checkEq("align_addr", imem_addr, 32'h0000_3100);
    doCycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);

    // PC wrap at the top of the address space.
    doCycle(1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    checkEq("wrap_top", imem_addr, 32'hFFFF_FFFC);
    doCycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    checkEq("wrap_addr", imem_addr, 32'h0000_0000);
    for (int i = 0; i < 3; i++) doCycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      rn = ($urandom_range(0, 99) != 0);
      st = ($urandom_range(0, 9) < 3);
      fl = ($urandom_range(0, 9) == 0);
      rd = ($urandom_range(0, 99) < 15);
      if ($urandom_range(0, 3) == 0) tg = $urandom();
      else tg = 32'h0000_3000 + (32'($urandom_range(0, 255)) << 2) + 32'($urandom_range(0, 3));
      doCycle(rn, st, fl, rd, tg);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
